// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   8-bit asynchronous serial receiver with optional odd/even parity.
//   The rx line passes through a two-flop synchronizer. A falling edge of the
//   synchronized line starts a frame, and the start bit is re-checked at
//   mid-bit so that short glitches are rejected. Data bits arrive LSB first.
//   After the stop bit, the byte and its error flags are published together
//   with a one-cycle data_valid strobe.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 4, even)
//
// Ports
//   clk            system clock; all state changes on the rising edge
//   rst            synchronous active-high reset
//   rx             serial input line (asynchronous, idle high)
//   parity_type    2'b01 odd, 2'b10 even, 2'b00/2'b11 no parity bit
//   data_out       last received byte
//   data_valid     one-cycle pulse when a frame completes
//   parity_error   parity mismatch flag for the last frame
//   framing_error  stop bit sampled low in the last frame
//   busy           high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_receiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [1:0] parity_type,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int SYNC_STAGES = 2;
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // ---------------------------------------------------------------------
    // Input synchronizer. The stages reset to 1 (line idle) so that leaving
    // reset never looks like a start edge.
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sync_reg[gi] <= 1'b1;
                    end else begin
                        sync_reg[gi] <= rx;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sync_reg[gi] <= 1'b1;
                    end else begin
                        sync_reg[gi] <= sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    logic rx_s;
    assign rx_s = sync_reg[SYNC_STAGES-1];

    // ---------------------------------------------------------------------
    // Receiver state
    // ---------------------------------------------------------------------
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       idx_reg;
    logic [7:0]       shift_reg;
    logic [1:0]       mode_reg;
    logic             par_err_reg;
    logic             rx_prev_reg;
    logic [7:0]       data_out_reg;
    logic             data_valid_reg;
    logic             parity_error_reg;
    logic             framing_error_reg;
    logic             busy_reg;

    // The mode is latched at the start edge, so a change on parity_type
    // mid-frame cannot affect the frame in progress.
    logic mode_has_parity;
    logic parity_expected;
    assign mode_has_parity = (mode_reg == 2'b01) || (mode_reg == 2'b10);
    assign parity_expected = (mode_reg == 2'b10) ? (^shift_reg) : (~^shift_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            idx_reg           <= '0;
            shift_reg         <= '0;
            mode_reg          <= '0;
            par_err_reg       <= 1'b0;
            rx_prev_reg       <= 1'b1;
            data_out_reg      <= 8'h00;
            data_valid_reg    <= 1'b0;
            parity_error_reg  <= 1'b0;
            framing_error_reg <= 1'b0;
            busy_reg          <= 1'b0;
        end else begin
            rx_prev_reg    <= rx_s;
            data_valid_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // Edge detect, not level detect: a line held low after a
                    // bad stop bit must go high again before a new frame.
                    if (rx_prev_reg && !rx_s) begin
                        mode_reg    <= parity_type;
                        cnt_reg     <= '0;
                        idx_reg     <= '0;
                        par_err_reg <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= START;
                    end
                end

                START: begin
                    if (cnt_reg == CNT_MID) begin
                        cnt_reg <= '0;
                        if (!rx_s) begin
                            state_reg <= DATA;
                        end else begin
                            // Line already high again: a glitch, not a start bit.
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                DATA: begin
                    // The counter was cleared at mid-start, so each wrap
                    // lands in the middle of the next bit.
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        idx_reg   <= idx_reg + 3'd1;
                        if (idx_reg == 3'd7) begin
                            state_reg <= mode_has_parity ? PARITY : STOP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                PARITY: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg     <= '0;
                        par_err_reg <= (rx_s != parity_expected);
                        state_reg   <= STOP;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                STOP: begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg           <= '0;
                        data_out_reg      <= shift_reg;
                        parity_error_reg  <= par_err_reg;
                        framing_error_reg <= ~rx_s;
                        data_valid_reg    <= 1'b1;
                        busy_reg          <= 1'b0;
                        state_reg         <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end

                default: begin
                    cnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign data_out      = data_out_reg;
    assign data_valid    = data_valid_reg;
    assign parity_error  = parity_error_reg;
    assign framing_error = framing_error_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//   Directed bench for uart_receiver with CLKS_PER_BIT = 16. Inputs are driven
//   1 time unit after a rising edge, and outputs are checked at that same
//   point. A negedge monitor counts data_valid pulses and records the cycle on
//   which each pulse was seen.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dv_count = 0;
    int dv_cyc = 0;
    int start_cyc = 0;
    int dv0;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .parity_type  (parity_type),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            dv_count = dv_count + 1;
            dv_cyc   = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        cycles(CPB);
    endtask

    // Sends start, 8 data bits LSB first, an optional parity bit and a stop
    // bit. parity_type switches to mid_pt after data bit 4 has been sent.
    task automatic send_frame(input logic [7:0] d, input logic use_par,
                              input logic par, input logic stop,
                              input logic [1:0] mid_pt);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            if (i == 4) parity_type = mid_pt;
        end
        if (use_par) send_bit(par);
        send_bit(stop);
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        parity_type = 2'b00;
        @(posedge clk);
        cycles(3);

        // Reset state
        chk("rst_data_out", {24'h0, data_out}, 32'h00);
        chk("rst_valid", {31'h0, data_valid}, 32'h0);
        chk("rst_perr", {31'h0, parity_error}, 32'h0);
        chk("rst_ferr", {31'h0, framing_error}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        cycles(5);

        // Even parity, 0x03, parity 0, stop 1
        parity_type = 2'b10;
        dv0 = dv_count;
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 2'b10);
        rx = 1'b1;
        cycles(10);
        chk("even_pulses", dv_count - dv0, 32'd1);
        chk("even_data", {24'h0, data_out}, 32'h03);
        chk("even_perr", {31'h0, parity_error}, 32'h0);
        chk("even_ferr", {31'h0, framing_error}, 32'h0);
        chk("even_busy", {31'h0, busy}, 32'h0);

        // Odd parity, 0x00, parity 0 -> error; mode switched mid-frame must not matter
        parity_type = 2'b01;
        dv0 = dv_count;
        send_frame(8'h00, 1'b1, 1'b0, 1'b1, 2'b00);
        rx = 1'b1;
        cycles(10);
        chk("odd0_pulses", dv_count - dv0, 32'd1);
        chk("odd0_data", {24'h0, data_out}, 32'h00);
        chk("odd0_perr", {31'h0, parity_error}, 32'h1);

        // Odd parity, 0x00, parity 1 -> clean
        parity_type = 2'b01;
        dv0 = dv_count;
        send_frame(8'h00, 1'b1, 1'b1, 1'b1, 2'b01);
        rx = 1'b1;
        cycles(10);
        chk("odd1_pulses", dv_count - dv0, 32'd1);
        chk("odd1_perr", {31'h0, parity_error}, 32'h0);

        // No parity, 0xA5; data_valid about 16*9.5 + sync latency after the start edge
        parity_type = 2'b00;
        dv0 = dv_count;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 2'b00);
        rx = 1'b1;
        cycles(10);
        chk("np_pulses", dv_count - dv0, 32'd1);
        chk("np_data", {24'h0, data_out}, 32'hA5);
        chk("np_perr", {31'h0, parity_error}, 32'h0);
        chk("np_latency_ok", {31'h0, ((dv_cyc - start_cyc) >= 152) && ((dv_cyc - start_cyc) <= 157)}, 32'h1);

        // Even parity, 0xFF, parity 0, stop 0 -> framing error; line held low afterwards
        parity_type = 2'b10;
        dv0 = dv_count;
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 2'b10);
        cycles(2);
        chk("fe_pulses", dv_count - dv0, 32'd1);
        chk("fe_data", {24'h0, data_out}, 32'hFF);
        chk("fe_ferr", {31'h0, framing_error}, 32'h1);
        chk("fe_perr", {31'h0, parity_error}, 32'h0);
        cycles(40);
        chk("fe_low_busy", {31'h0, busy}, 32'h0);
        chk("fe_low_pulses", dv_count - dv0, 32'd1);
        rx = 1'b1;
        cycles(10);
        dv0 = dv_count;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 2'b10);
        rx = 1'b1;
        cycles(10);
        chk("after_fe_pulses", dv_count - dv0, 32'd1);
        chk("after_fe_data", {24'h0, data_out}, 32'h3C);
        chk("after_fe_ferr", {31'h0, framing_error}, 32'h0);

        // Start glitch: rx low for 4 cycles
        dv0 = dv_count;
        rx = 1'b0;
        cycles(4);
        rx = 1'b1;
        cycles(3);
        chk("glitch_busy_hi", {31'h0, busy}, 32'h1);
        cycles(8);
        chk("glitch_busy_lo", {31'h0, busy}, 32'h0);
        chk("glitch_pulses", dv_count - dv0, 32'd0);
        chk("glitch_data", {24'h0, data_out}, 32'h3C);
        cycles(10);

        // Reset during data bit 3, then a clean 0x5A frame
        parity_type = 2'b00;
        dv0 = dv_count;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b1;
        cycles(CPB / 2);
        chk("mid_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        cycles(1);
        chk("mrst_busy", {31'h0, busy}, 32'h0);
        chk("mrst_data", {24'h0, data_out}, 32'h00);
        chk("mrst_valid", {31'h0, data_valid}, 32'h0);
        chk("mrst_perr", {31'h0, parity_error}, 32'h0);
        chk("mrst_ferr", {31'h0, framing_error}, 32'h0);
        rst = 1'b0;
        rx = 1'b1;
        cycles(20);
        chk("mrst_pulses", dv_count - dv0, 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 2'b00);
        rx = 1'b1;
        cycles(10);
        chk("post_rst_pulses", dv_count - dv0, 32'd1);
        chk("post_rst_data", {24'h0, data_out}, 32'h5A);
        chk("post_rst_ferr", {31'h0, framing_error}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
